// File: rtl/vx_decode_ibuf.sv
// Per-issue-slot instruction buffer between decode and scoreboard; steers by warp id.
// Optional same-cycle bypass into an empty slot is enabled by defining IBUF_BYPASS_EN.
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 4
`endif

module vx_decode_ibuf #(
  parameter int ISSUE_WIDTH = `ISSUE_WIDTH,
  parameter int DEPTH       = 4,
  parameter int DATAW       = 32,
  parameter int WID_LSB     = 0
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      decode_valid,
  input  logic [DATAW-1:0]                          decode_data,
  output logic                                      decode_ready,
  output logic [ISSUE_WIDTH-1:0]                    decode_ibuf_pop,
  output logic [ISSUE_WIDTH-1:0]                    ibuf_valid,
  output logic [ISSUE_WIDTH*DATAW-1:0]              ibuf_data,
  input  logic [ISSUE_WIDTH-1:0]                    ibuf_ready,
  output logic [ISSUE_WIDTH*($clog2(DEPTH)+1)-1:0]  ibuf_count
);

  localparam int SELW = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [DATAW-1:0] mem    [ISSUE_WIDTH][DEPTH];
  logic [PTRW-1:0]  rd_ptr [ISSUE_WIDTH];
  logic [PTRW-1:0]  wr_ptr [ISSUE_WIDTH];
  logic [CNTW-1:0]  count  [ISSUE_WIDTH];

  logic [SELW-1:0]        sel;
  logic [ISSUE_WIDTH-1:0] full;
  logic [ISSUE_WIDTH-1:0] empty;
  logic [ISSUE_WIDTH-1:0] push;
  logic [ISSUE_WIDTH-1:0] wr;
  logic [ISSUE_WIDTH-1:0] rd;
  logic [ISSUE_WIDTH-1:0] hs;

  generate
    if (ISSUE_WIDTH == 1) begin : g_sel_single
      assign sel = '0;
    end else begin : g_sel_multi
      assign sel = decode_data[WID_LSB +: SELW];
    end
  endgenerate

  always_comb begin
    full       = '0;
    empty      = '0;
    ibuf_count = '0;
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      full[i]                     = (count[i] == CNTW'(DEPTH));
      empty[i]                    = (count[i] == '0);
      ibuf_count[i*CNTW +: CNTW]  = count[i];
    end
  end

  // Ready only looks at registered occupancy, so a full slot refuses even while it pops.
  assign decode_ready = !full[sel];

  always_comb begin
    push       = '0;
    wr         = '0;
    rd         = '0;
    hs         = '0;
    ibuf_valid = '0;
    ibuf_data  = '0;
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      push[i]                     = decode_valid && decode_ready && (sel == SELW'(i));
      ibuf_valid[i]               = !empty[i];
      ibuf_data[i*DATAW +: DATAW] = mem[i][rd_ptr[i]];
`ifdef IBUF_BYPASS_EN
      if (empty[i] && decode_valid && (sel == SELW'(i))) begin
        ibuf_valid[i]               = 1'b1;
        ibuf_data[i*DATAW +: DATAW] = decode_data;
      end
`endif
      hs[i] = ibuf_valid[i] && ibuf_ready[i];
      // A handshake on an empty slot can only be a bypass: nothing is stored or read.
      rd[i] = hs[i] && !empty[i];
      wr[i] = push[i] && !(empty[i] && hs[i]);
    end
  end

  assign decode_ibuf_pop = hs;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
        if (wr[i]) wr_ptr[i] <= wr_ptr[i] + PTRW'(1);
        if (rd[i]) rd_ptr[i] <= rd_ptr[i] + PTRW'(1);
        case ({wr[i], rd[i]})
          2'b10:   count[i] <= count[i] + CNTW'(1);
          2'b01:   count[i] <= count[i] - CNTW'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (|wr) mem[sel][wr_ptr[sel]] <= decode_data;
  end

endmodule

// File: tb/tb_vx_decode_ibuf.sv
// Directed self-checking bench for vx_decode_ibuf (ISSUE_WIDTH=4, DEPTH=4, wid at bits [9:8]).
// Expectations for the final scenario follow IBUF_BYPASS_EN when it is defined.
module tb_vx_decode_ibuf;

  localparam int IW    = 4;
  localparam int DEP   = 4;
  localparam int DW    = 16;
  localparam int CW    = 3;

  logic              clk;
  logic              reset;
  logic              decode_valid;
  logic [DW-1:0]     decode_data;
  logic              decode_ready;
  logic [IW-1:0]     decode_ibuf_pop;
  logic [IW-1:0]     ibuf_valid;
  logic [IW*DW-1:0]  ibuf_data;
  logic [IW-1:0]     ibuf_ready;
  logic [IW*CW-1:0]  ibuf_count;

  int n_checks = 0;
  int n_errors = 0;

  vx_decode_ibuf #(
    .ISSUE_WIDTH (IW),
    .DEPTH       (DEP),
    .DATAW       (DW),
    .WID_LSB     (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .decode_valid    (decode_valid),
    .decode_data     (decode_data),
    .decode_ready    (decode_ready),
    .decode_ibuf_pop (decode_ibuf_pop),
    .ibuf_valid      (ibuf_valid),
    .ibuf_data       (ibuf_data),
    .ibuf_ready      (ibuf_ready),
    .ibuf_count      (ibuf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mk(input int w, input int t);
    logic [1:0] wb;
    logic [7:0] tb;
    wb = 2'(w);
    tb = 8'(t);
    return {6'h2A, wb, tb};
  endfunction

  function automatic logic [CW-1:0] cnt(input int s);
    return ibuf_count[s*CW +: CW];
  endfunction

  function automatic logic [DW-1:0] head(input int s);
    return ibuf_data[s*DW +: DW];
  endfunction

  initial begin
    int sent;
    int got;

    reset        = 1'b0;
    decode_valid = 1'b0;
    decode_data  = '0;
    ibuf_ready   = '0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rst_valid", ibuf_valid, 4'b0000);
    check("rst_count", ibuf_count, 12'h000);
    check("rst_pop", decode_ibuf_pop, 4'b0000);
    check("rst_ready", decode_ready, 1'b1);

    // Single push to slot 1, then pop it.
    decode_valid = 1'b1;
    decode_data  = mk(1, 8'h11);
    #1;
    check("t1_ready", decode_ready, 1'b1);
    tick();
    decode_valid = 1'b0;
    #1;
    check("t1_valid", ibuf_valid, 4'b0010);
    check("t1_data", head(1), mk(1, 8'h11));
    check("t1_count", cnt(1), 3'd1);
    ibuf_ready = 4'b0010;
    #1;
    check("t1_pop", decode_ibuf_pop, 4'b0010);
    tick();
    ibuf_ready = 4'b0000;
    #1;
    check("t1_pop_off", decode_ibuf_pop, 4'b0000);
    check("t1_valid_off", ibuf_valid, 4'b0000);
    check("t1_count0", cnt(1), 3'd0);

    // Fill slot 2; slot 3 must still accept.
    for (int k = 0; k < 4; k++) begin
      decode_valid = 1'b1;
      decode_data  = mk(2, 8'h20 + k);
      #1;
      check("t2_fill_ready", decode_ready, 1'b1);
      tick();
    end
    decode_data = mk(2, 8'h24);
    #1;
    check("t2_full_ready", decode_ready, 1'b0);
    check("t2_count", cnt(2), 3'd4);
    decode_data = mk(3, 8'h30);
    #1;
    check("t2_other_ready", decode_ready, 1'b1);
    tick();
    decode_valid = 1'b0;
    #1;
    check("t2_count3", cnt(3), 3'd1);
    check("t2_valid", ibuf_valid, 4'b1100);

    // Full slot 2: pop and push together; push is refused until the next cycle.
    decode_valid = 1'b1;
    decode_data  = mk(2, 8'h24);
    ibuf_ready   = 4'b0100;
    #1;
    check("t3_ready", decode_ready, 1'b0);
    check("t3_pop", decode_ibuf_pop, 4'b0100);
    check("t3_head", head(2), mk(2, 8'h20));
    tick();
    ibuf_ready = 4'b0000;
    #1;
    check("t3_count3", cnt(2), 3'd3);
    check("t3_ready2", decode_ready, 1'b1);
    tick();
    decode_valid = 1'b0;
    #1;
    check("t3_count4", cnt(2), 3'd4);
    ibuf_ready = 4'b1100;
    for (int k = 1; k < 5; k++) begin
      #1;
      check("t3_drain2", head(2), mk(2, 8'h20 + k));
      if (k == 1) check("t3_drain3", head(3), mk(3, 8'h30));
      tick();
      ibuf_ready = 4'b0100;
    end
    ibuf_ready = 4'b0000;
    #1;
    check("t3_empty", ibuf_count, 12'h000);

    // Stream 10 entries to slot 0 with ready toggling.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      ibuf_ready   = (c % 2 == 0) ? 4'b0001 : 4'b0000;
      decode_valid = (sent < 10);
      decode_data  = mk(0, 8'h40 + sent);
      #1;
      if (decode_ibuf_pop[0]) begin
        check("t4_order", head(0), mk(0, 8'h40 + got));
        got++;
      end
      if (decode_valid && decode_ready) sent++;
      tick();
    end
    decode_valid = 1'b0;
    ibuf_ready   = 4'b0000;
    #1;
    check("t4_popped", got, 10);
    check("t4_count", cnt(0), 3'd0);

    // Reset with three entries in slot 1.
    for (int k = 0; k < 3; k++) begin
      decode_valid = 1'b1;
      decode_data  = mk(1, 8'h50 + k);
      tick();
    end
    decode_valid = 1'b0;
    #1;
    check("t5_pre_count", cnt(1), 3'd3);
    reset = 1'b0;
    tick();
    reset      = 1'b1;
    ibuf_ready = 4'b0010;
    #1;
    check("t5_valid", ibuf_valid, 4'b0000);
    check("t5_count", ibuf_count, 12'h000);
    check("t5_pop", decode_ibuf_pop, 4'b0000);
    ibuf_ready = 4'b0000;

    // Push into empty slot 0 with ready high.
    decode_valid = 1'b1;
    decode_data  = mk(0, 8'h66);
    ibuf_ready   = 4'b0001;
    #1;
`ifdef IBUF_BYPASS_EN
    check("t6_valid", ibuf_valid, 4'b0001);
    check("t6_pop", decode_ibuf_pop, 4'b0001);
    check("t6_data", head(0), mk(0, 8'h66));
`else
    check("t6_valid", ibuf_valid, 4'b0000);
    check("t6_pop", decode_ibuf_pop, 4'b0000);
`endif
    tick();
    decode_valid = 1'b0;
    #1;
`ifdef IBUF_BYPASS_EN
    check("t6_count", cnt(0), 3'd0);
    check("t6_valid_next", ibuf_valid, 4'b0000);
`else
    check("t6_count", cnt(0), 3'd1);
    check("t6_valid_next", ibuf_valid, 4'b0001);
    check("t6_pop_next", decode_ibuf_pop, 4'b0001);
    check("t6_data", head(0), mk(0, 8'h66));
    tick();
    #1;
    check("t6_count_end", cnt(0), 3'd0);
`endif
    ibuf_ready = 4'b0000;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vx_decode_ibuf.md
# vx_decode_ibuf

Per-issue-slot instruction buffer that terminates the consumer end of the decode stage's valid/data/ready stream. It steers each decoded instruction into one of ISSUE_WIDTH FIFOs, selected by the instruction's warp id. It presents each FIFO head to the issue/scoreboard stage and returns per-slot ibuf_pop strobes to the decoder. The block sits between decode and scoreboard, one instance per core.

## Interface
- ISSUE_WIDTH, `ISSUE_WIDTH: number of issue slots; power of 2, ≥1.
- DEPTH, 4: entries per slot FIFO; power of 2, ≥2.
- DATAW, width of decode data_t: width of one decoded instruction word.
- WID_LSB, bit position of the wid LSB inside the data word: selects the warp id field used for slot steering.
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- decode_valid  in  1  decoded instruction valid.
- decode_data  in  DATAW  decoded instruction (uuid, wid, tmask, ex/op, operands, PC, imm, regs, is_branch).
- decode_ready  out  1  instruction accepted when high with decode_valid.
- decode_ibuf_pop  out  ISSUE_WIDTH  bit i pulses for one cycle when slot i dequeues one entry.
- ibuf_valid  out  ISSUE_WIDTH  slot i head valid.
- ibuf_data  out  ISSUE_WIDTH*DATAW  slot i head, at bits [i*DATAW +: DATAW].
- ibuf_ready  in  ISSUE_WIDTH  downstream accepts slot i head.
- ibuf_count  out  ISSUE_WIDTH*(log2(DEPTH)+1)  per-slot occupancy, for performance counters.

## Operation
- Slot select: sel = decode_data[WID_LSB +: log2(ISSUE_WIDTH)]. When ISSUE_WIDTH=1, sel = 0.
- decode_ready = !full[sel]. It depends only on decode_data and registered state, never on ibuf_ready, so there is no combinational ready path through the buffer.
- Push: decode_valid & decode_ready writes mem[sel][wr_ptr[sel]]; wr_ptr increments modulo DEPTH.
- Pop: ibuf_valid[i] & ibuf_ready[i] increments rd_ptr[i] modulo DEPTH. decode_ibuf_pop[i] equals that handshake, combinationally.
- ibuf_valid[i] = (count[i] != 0). ibuf_data[i] = mem[i][rd_ptr[i]].
- Count update per slot:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged, with both pointers advanced.
- Full slot: no push is accepted, even when a pop occurs that same cycle. The freed entry is accepted on the next cycle.
- Empty slot: ibuf_valid=0 and pop is impossible. ibuf_data content is don't-care.
- Slots are fully independent. One slot being full never stalls pushes steered to another slot, because ready is evaluated per instruction.
- Ordering: FIFO order is preserved per slot. No ordering is guaranteed across slots.
- Pointer width is log2(DEPTH). Wrap-around is natural power-of-2 overflow. The count width is log2(DEPTH)+1 so that DEPTH is representable.

## Timing
- Reset (reset=0 at a clk edge): all pointers and counts are cleared and buffered entries are discarded.
  - ibuf_valid=0, decode_ibuf_pop=0, ibuf_count=0.
  - decode_ready=1 from the first cycle after reset.
  - Reset mid-operation drops in-flight entries without emitting any pop strobes.
- Latency without bypass: an instruction accepted at edge N appears on ibuf_valid after edge N, i.e. 1 cycle.
- Throughput: 1 push per cycle total, plus up to 1 pop per slot per cycle.
- Memory has no reset. Only control state is reset.

## Configuration
- IBUF_BYPASS_EN defined:
  - When slot sel is empty and decode_valid is high, ibuf_valid[sel]=1 and ibuf_data[sel]=decode_data in the same cycle.
  - If ibuf_ready[sel] is also high, the instruction passes through with no write and no count change, and decode_ibuf_pop[sel] pulses that cycle. Latency is 0.
  - decode_ready is unchanged (!full), so the ready path is still not combinational.
- IBUF_BYPASS_EN undefined: no bypass; minimum latency is 1 cycle as above.

## Test plan
- Reset, then push wid=1 with ISSUE_WIDTH=4: accepted in 1 cycle; ibuf_valid=4'b0010 next cycle; pop asserts decode_ibuf_pop=4'b0010 for exactly 1 cycle; count returns to 0.
- Fill slot 2 with DEPTH=4 while ibuf_ready=0: 4 accepts, then decode_ready=0 for wid=2 while wid=3 is still accepted; count[2]=4.
- With slot 2 full, drive pop and push together: pop completes and push is rejected that cycle; next cycle the push is accepted and count[2] stays 4.
- Stream 10 instructions to slot 0 with ibuf_ready toggling 1,0,1,0: output sequence matches input order, exercising pointer wrap at 4 and simultaneous push/pop with count steady.
- Assert reset with 3 entries in slot 1: the next cycle shows ibuf_valid=0, count=0, and no decode_ibuf_pop pulse.
- IBUF_BYPASS_EN with slot empty and ibuf_ready=1: ibuf_valid and decode_ibuf_pop are high in the same cycle as decode_valid; count stays 0. Without the macro, the same stimulus shows valid one cycle later.
